// File: rtl/mem_responder.sv
// Memory-side responder for the 16-bit multicycle datapath.
// Serves word reads/writes from an on-chip RAM or a small I/O page
// (switches, LEDs, hex display, cycle counter). Each transaction takes
// IDLE -> ACCESS -> RESP, and MEM_ACK pulses during RESP.
module mem_responder #(
    parameter int WIDTH     = 16,
    parameter int ADDR_BITS = 10,
    parameter int IO_BITS   = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               MEM_REQ,
    input  logic               MEM_WE,
    input  logic [WIDTH-1:0]   MEM_ADDR,
    input  logic [WIDTH-1:0]   MEM_WDATA,
    output logic [WIDTH-1:0]   MEM_OUT,
    output logic               MEM_ACK,
    output logic               BUSY,
    output logic               ERR,
    input  logic [IO_BITS-1:0] SW_IN,
    output logic [IO_BITS-1:0] LED_OUT,
    output logic [WIDTH-1:0]   HEX_OUT
);

    localparam logic [WIDTH-1:0] SW_ADDR  = WIDTH'(16'hFF00);
    localparam logic [WIDTH-1:0] LED_ADDR = WIDTH'(16'hFF01);
    localparam logic [WIDTH-1:0] HEX_ADDR = WIDTH'(16'hFF02);
    localparam logic [WIDTH-1:0] CNT_ADDR = WIDTH'(16'hFF03);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t             state, next_state;
    logic [WIDTH-1:0]   addr_q, wdata_q;
    logic               we_q;
    logic [WIDTH-1:0]   cycle_cnt;
    logic [IO_BITS-1:0] sw_meta, sw_sync;
    logic [WIDTH-1:0]   ram [0:(1<<ADDR_BITS)-1];

    logic               in_ram;
    logic               bad_access;
    logic [WIDTH-1:0]   rd_val;

    // State register; an async reset abandons any in-flight transaction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state: requests are only taken in IDLE, ACCESS and RESP last one cycle
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (MEM_REQ) next_state = ACCESS;
            ACCESS:  next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Status outputs decoded straight from the state
    always_comb begin
        BUSY    = (state != IDLE);
        MEM_ACK = (state == RESP);
    end

    // Address decode of the latched request: read value and error condition
    always_comb begin
        in_ram     = ((addr_q >> ADDR_BITS) == '0);
        rd_val     = '0;
        bad_access = 1'b0;
        if (in_ram) begin
            rd_val = ram[addr_q[ADDR_BITS-1:0]];
        end else if (addr_q == SW_ADDR) begin
            rd_val     = WIDTH'(sw_sync);
            bad_access = we_q;
        end else if (addr_q == LED_ADDR) begin
            rd_val = WIDTH'(LED_OUT);
        end else if (addr_q == HEX_ADDR) begin
            rd_val = HEX_OUT;
        end else if (addr_q == CNT_ADDR) begin
            rd_val     = cycle_cnt;
            bad_access = we_q;
        end else begin
            bad_access = 1'b1;
        end
    end

    // Request latch, free-running counter and two-flop switch synchronizer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            cycle_cnt <= '0;
            sw_meta   <= '0;
            sw_sync   <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + WIDTH'(1);
            sw_meta   <= SW_IN;
            sw_sync   <= sw_meta;
            if (state == IDLE && MEM_REQ) begin
                addr_q  <= MEM_ADDR;
                wdata_q <= MEM_WDATA;
                we_q    <= MEM_WE;
            end
        end
    end

    // ACCESS closing edge: read data, I/O register writes and sticky error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            MEM_OUT <= '0;
            LED_OUT <= '0;
            HEX_OUT <= '0;
            ERR     <= 1'b0;
        end else if (state == ACCESS) begin
            if (!we_q)                   MEM_OUT <= rd_val;
            else if (addr_q == LED_ADDR) LED_OUT <= wdata_q[IO_BITS-1:0];
            else if (addr_q == HEX_ADDR) HEX_OUT <= wdata_q;
            if (bad_access) ERR <= 1'b1;
        end
    end

    // RAM write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (state == ACCESS && we_q && in_ram)
            ram[addr_q[ADDR_BITS-1:0]] <= wdata_q;
    end

endmodule
